// File: rtl/deser_align_ctrl.sv
// Word-alignment and link-sync controller: finds the comma at any bit offset, qualifies lock, emits aligned bytes.
// Optional macro DESER_ALIGN_STATS_EN adds a saturating lock-loss counter output (lock_loss_cnt).
module deser_align_ctrl #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         ACQ_COUNT  = 3,
    parameter int         LOSS_COUNT = 4,
    parameter int         COUNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       data,
    input  logic       DK,
    output logic [7:0] out,
    output logic       out_DK,
    output logic       out_valid,
    output logic       code_err,
    output logic       sync,
    output logic [1:0] state
`ifdef DESER_ALIGN_STATS_EN
    ,
    output logic [15:0] lock_loss_cnt
`endif
);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] ACQ  = 2'd1;
    localparam logic [1:0] SYNC = 2'd2;

    localparam logic [COUNT_W-1:0] ACQ_MAX  = COUNT_W'(ACQ_COUNT);
    localparam logic [COUNT_W-1:0] LOSS_MAX = COUNT_W'(LOSS_COUNT);
    localparam logic [COUNT_W-1:0] ONE      = COUNT_W'(1);

    // Only seven history bits are kept; the eighth bit of a word is always the live input.
    logic [6:0]         shreg;
    logic [2:0]         bitcnt;
    logic [COUNT_W-1:0] acq;
    logic [COUNT_W-1:0] err;

    logic [7:0]         word;
    logic               boundary;
    logic               is_comma;
    logic               is_kerr;
    logic [COUNT_W-1:0] acq_inc;
    logic [COUNT_W-1:0] err_inc;

    assign word     = {shreg, data};
    assign boundary = (bitcnt == 3'd7);
    assign is_comma = (word == COMMA) && DK;
    assign is_kerr  = DK && (word != COMMA);
    assign acq_inc  = acq + ONE;
    assign err_inc  = err + ONE;

    logic [1:0]         state_nxt;
    logic [2:0]         bitcnt_nxt;
    logic [COUNT_W-1:0] acq_nxt;
    logic [COUNT_W-1:0] err_nxt;
    logic               emit;
    logic               kerr;

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt + 3'd1;
        acq_nxt    = acq;
        err_nxt    = err;
        emit       = 1'b0;
        kerr       = 1'b0;
        case (state)
            HUNT: begin
                // A comma at any offset re-anchors the word boundary right after it.
                if (is_comma) begin
                    bitcnt_nxt = 3'd0;
                    acq_nxt    = ONE;
                    if (ACQ_COUNT == 1) begin
                        state_nxt = SYNC;
                        err_nxt   = '0;
                    end else begin
                        state_nxt = ACQ;
                    end
                end
            end
            ACQ: begin
                if (boundary) begin
                    if (is_comma) begin
                        acq_nxt = acq_inc;
                        if (acq_inc == ACQ_MAX) begin
                            state_nxt = SYNC;
                            err_nxt   = '0;
                        end
                    end else begin
                        state_nxt = HUNT;
                        acq_nxt   = '0;
                    end
                end
            end
            SYNC: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (is_kerr) begin
                        kerr = 1'b1;
                        if (err_inc == LOSS_MAX) begin
                            state_nxt = HUNT;
                            acq_nxt   = '0;
                            err_nxt   = '0;
                        end else begin
                            err_nxt = err_inc;
                        end
                    end else if (is_comma) begin
                        err_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                acq_nxt   = '0;
                err_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bitcnt    <= '0;
            acq       <= '0;
            err       <= '0;
            state     <= HUNT;
            sync      <= 1'b0;
            out       <= '0;
            out_DK    <= 1'b0;
            out_valid <= 1'b0;
            code_err  <= 1'b0;
        end else if (!enable) begin
            out_valid <= 1'b0;
            code_err  <= 1'b0;
        end else begin
            shreg     <= word[6:0];
            bitcnt    <= bitcnt_nxt;
            acq       <= acq_nxt;
            err       <= err_nxt;
            state     <= state_nxt;
            sync      <= (state_nxt == SYNC);
            out_valid <= emit;
            code_err  <= kerr;
            if (emit) begin
                out    <= word;
                out_DK <= DK;
            end
        end
    end

`ifdef DESER_ALIGN_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_loss_cnt <= '0;
        end else if (enable && state == SYNC && state_nxt == HUNT && lock_loss_cnt != 16'hFFFF) begin
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Scoreboard bench for deser_align_ctrl: a byte-level reference model queues expectations, a monitor checks them.
module tb_deser_align_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       data = 1'b0;
    logic       DK = 1'b0;
    logic [7:0] out;
    logic       out_DK;
    logic       out_valid;
    logic       code_err;
    logic       sync;
    logic [1:0] state;
`ifdef DESER_ALIGN_STATS_EN
    logic [15:0] lock_loss_cnt;
`endif

    deser_align_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .data      (data),
        .DK        (DK),
        .out       (out),
        .out_DK    (out_DK),
        .out_valid (out_valid),
        .code_err  (code_err),
        .sync      (sync),
        .state     (state)
`ifdef DESER_ALIGN_STATS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam int ACQ_N  = 3;
    localparam int LOSS_N = 4;
    localparam logic [7:0] K_COMMA = 8'hBC;

    typedef struct {
        int   st;
        logic vld;
        logic cerr;
    } cycle_exp_t;

    cycle_exp_t  cycle_q[$];
    logic [8:0]  out_q[$];

    int checks = 0;
    int errors = 0;
    int code_err_seen = 0;
    bit rand_gaps = 0;

    // Reference model: link mode, bits since the locked boundary, last eight bits received.
    int         m_mode;
    int         m_bits;
    logic [7:0] m_last8;
    int         m_commas;
    int         m_kerrs;
    int         m_losses;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_bits   = 0;
        m_last8  = 8'h00;
        m_commas = 0;
        m_kerrs  = 0;
        m_losses = 0;
    endtask

    task automatic model_step(input logic en, input logic d, input logic dk);
        cycle_exp_t e;
        bit at_word_end;
        bit comma;
        e.vld  = 1'b0;
        e.cerr = 1'b0;
        if (en) begin
            m_last8     = {m_last8[6:0], d};
            at_word_end = (m_bits % 8) == 7;
            m_bits      = m_bits + 1;
            comma       = (m_last8 == K_COMMA) && dk;
            if (m_mode == 0) begin
                if (comma) begin
                    m_bits   = 0;
                    m_commas = 1;
                    m_mode   = (ACQ_N == 1) ? 2 : 1;
                    m_kerrs  = 0;
                end
            end else if (m_mode == 1) begin
                if (at_word_end) begin
                    if (comma) begin
                        m_commas++;
                        if (m_commas == ACQ_N) begin
                            m_mode  = 2;
                            m_kerrs = 0;
                        end
                    end else begin
                        m_mode   = 0;
                        m_commas = 0;
                    end
                end
            end else if (at_word_end) begin
                e.vld = 1'b1;
                out_q.push_back({dk, m_last8});
                if (dk && !comma) begin
                    e.cerr = 1'b1;
                    m_kerrs++;
                    if (m_kerrs == LOSS_N) begin
                        m_mode   = 0;
                        m_kerrs  = 0;
                        m_commas = 0;
                        if (m_losses < 65535) m_losses++;
                    end
                end else if (comma) begin
                    m_kerrs = 0;
                end
            end
        end
        e.st = m_mode;
        cycle_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic en, input logic d, input logic dk);
        @(negedge clk);
        enable = en;
        data   = d;
        DK     = dk;
        model_step(en, d, dk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic dk);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, b[i], dk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dk, input int gap_pos, input int gap_len);
        for (int i = 7; i >= 0; i--) begin
            if (i == gap_pos) begin
                for (int g = 0; g < gap_len; g++) applyStimulus(1'b0, 1'($urandom), 1'($urandom));
            end else if (rand_gaps && $urandom_range(15) == 0) begin
                for (int g = 0; g < int'($urandom_range(3, 1)); g++)
                    applyStimulus(1'b0, 1'($urandom), 1'($urandom));
            end
            applyStimulus(1'b1, b[i], dk);
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any clock arrives.
    task automatic do_reset();
        @(posedge clk);
        #2;
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        checkOutput("rst_out", 16'(out), 16'h0);
        checkOutput("rst_out_DK", 16'(out_DK), 16'h0);
        checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
        checkOutput("rst_code_err", 16'(code_err), 16'h0);
        checkOutput("rst_sync", 16'(sync), 16'h0);
        checkOutput("rst_state", 16'(state), 16'h0);
`ifdef DESER_ALIGN_STATS_EN
        checkOutput("rst_lock_loss_cnt", lock_loss_cnt, 16'h0);
`endif
        cycle_q.delete();
        out_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        cycle_exp_t e;
        logic [8:0] o;
        forever begin
            @(posedge clk);
            #1;
            if (code_err === 1'b1) code_err_seen++;
            if (cycle_q.size() > 0) begin
                e = cycle_q.pop_front();
                checkOutput("state", 16'(state), 16'(e.st));
                checkOutput("sync", 16'(sync), 16'(e.st == 2));
                checkOutput("out_valid", 16'(out_valid), 16'(e.vld));
                checkOutput("code_err", 16'(code_err), 16'(e.cerr));
                if (out_valid === 1'b1) begin
                    if (out_q.size() == 0) begin
                        checkOutput("unexpected_out", 16'(out), 16'hFFFF);
                    end else begin
                        o = out_q.pop_front();
                        checkOutput("out", 16'(out), 16'(o[7:0]));
                        checkOutput("out_DK", 16'(out_DK), 16'(o[8]));
                    end
                end else if (e.vld && out_q.size() > 0) begin
                    void'(out_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] b;
        int         kind;
        model_reset();
        #1;
        checkOutput("init_state", 16'(state), 16'h0);
        checkOutput("init_out_valid", 16'(out_valid), 16'h0);
        do_reset();

        // Three junk bits, three commas, then a data byte.
        send_bits(8'b0000_0101, 3, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(K_COMMA, 1'b1, -1, 0);
        send_byte(8'h5A, 1'b0, -1, 0);
        settle();
        checkOutput("t2_sync_held", 16'(sync), 16'h1);

        // Broken acquisition: a non-comma K code after two commas.
        do_reset();
        for (int i = 0; i < 2; i++) send_byte(K_COMMA, 1'b1, -1, 0);
        send_byte(8'h1C, 1'b1, -1, 0);
        send_byte(8'h33, 1'b0, -1, 0);
        settle();
        checkOutput("t3_state_hunt", 16'(state), 16'h0);

        // Error counting: comma clears the count; the fourth consecutive error drops lock.
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(K_COMMA, 1'b1, -1, 0);
        settle();
        code_err_seen = 0;
        for (int i = 0; i < 3; i++) send_byte(8'hFE, 1'b1, -1, 0);
        send_byte(K_COMMA, 1'b1, -1, 0);
        for (int i = 0; i < 3; i++) send_byte(8'hFE, 1'b1, -1, 0);
        settle();
        checkOutput("t4_sync_before_last", 16'(sync), 16'h1);
        send_byte(8'hFE, 1'b1, -1, 0);
        settle();
        checkOutput("t4_code_err_pulses", 16'(code_err_seen), 16'd7);
        checkOutput("t4_sync_dropped", 16'(sync), 16'h0);
`ifdef DESER_ALIGN_STATS_EN
        checkOutput("t4_lock_loss_cnt", lock_loss_cnt, 16'd1);
`endif

        // Enable held low for five cycles mid-word, then alignment continues.
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(K_COMMA, 1'b1, -1, 0);
        send_byte(8'hC3, 1'b0, 4, 5);
        send_byte(8'h96, 1'b0, -1, 0);
        send_byte(8'h0F, 1'b0, -1, 0);

        // Comma landing three bits after a previous word boundary.
        do_reset();
        send_byte(8'h00, 1'b0, -1, 0);
        send_bits(8'b0000_0110, 3, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(K_COMMA, 1'b1, -1, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, -1, 0);

        // Randomized traffic with slips, K errors, enable gaps and occasional resets.
        rand_gaps = 1;
        for (int ep = 0; ep < 50; ep++) begin
            if (ep % 12 == 11) do_reset();
            send_bits(8'($urandom), int'($urandom_range(7)), 1'b0);
            for (int i = 0; i < int'($urandom_range(3, 1)); i++) send_byte(K_COMMA, 1'b1, -1, 0);
            for (int i = 0; i < int'($urandom_range(14, 4)); i++) begin
                kind = int'($urandom_range(9));
                b    = 8'($urandom);
                if (kind < 7)      send_byte(b, 1'b0, -1, 0);
                else if (kind < 8) send_byte(K_COMMA, 1'b1, -1, 0);
                else               send_byte(b, 1'b1, -1, 0);
            end
        end
        rand_gaps = 0;

        settle();
        enable = 1'b0;
        settle();
        checkOutput("queue_drained", 16'(out_q.size()), 16'h0);
`ifdef DESER_ALIGN_STATS_EN
        checkOutput("final_lock_loss_cnt", lock_loss_cnt, 16'(m_losses));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
